// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC vectoring block: widths, FSM encoding,
// the pi/2 constant and the atan(2^-i) table in 3Q29 radians.
package cordic_pkg;

  localparam int XY_W     = 34;
  localparam int Z_W      = 32;
  localparam int TAB_FRAC = 29;
  localparam int IDX_W    = 5;

  localparam logic signed [Z_W-1:0] PI_2 = 32'sd843314857;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // round(atan(2^-i) * 2^29) for i = 0..29; two zero entries pad to a full 5-bit index
  localparam logic [Z_W-1:0] ATAN_TAB [32] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384,
    32'd8192,      32'd4096,      32'd2048,      32'd1024,
    32'd512,       32'd256,       32'd128,       32'd64,
    32'd32,        32'd16,        32'd8,         32'd4,
    32'd2,         32'd1,         32'd0,         32'd0
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, rescaled from the 29-bit table to the
// requested number of fractional angle bits.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANG_FRAC = 29
) (
  input  logic [IDX_W-1:0] i,
  output logic [Z_W-1:0]   angle
);

  assign angle = ATAN_TAB[i] >> (TAB_FRAC - ANG_FRAC);

endmodule

// File: rtl/cordic_vec.sv
// Iterative CORDIC in vectoring mode: converts (XIN, YIN) to an unscaled
// modulus XF and atan2 angle ANGLE, one micro-rotation per clock.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// ROT   | one micro-rotation per cycle, then hand x/z to the outputs
// FIN   | result valid, done high for this single cycle
module cordic_vec
  import cordic_pkg::*;
#(
  parameter int NITER    = 24,
  parameter int ANG_FRAC = 29
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       XIN,
  input  logic [31:0]       YIN,
  output logic              busy,
  output logic              done,
  output logic [XY_W-1:0]   XF,
  output logic [Z_W-1:0]    ANGLE
);

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NITER);
  localparam logic signed [Z_W-1:0] PI_2_S = PI_2 >>> (TAB_FRAC - ANG_FRAC);

  state_t state_q, state_d;
  logic [IDX_W-1:0]        i_q, i_d;
  logic signed [XY_W-1:0]  x_q, x_d, y_q, y_d;
  logic signed [Z_W-1:0]   z_q, z_d;
  logic                    zero_q, zero_d;
  logic [XY_W-1:0]         xf_q, xf_d;
  logic [Z_W-1:0]          ang_q, ang_d;

  logic signed [XY_W-1:0]  xe, ye, x_sh, y_sh;
  logic [Z_W-1:0]          atan_i;

  cordic_atan_rom #(.ANG_FRAC(ANG_FRAC)) u_atan_rom (
    .i     (i_q),
    .angle (atan_i)
  );

  // Extending before any negation keeps -2^31 exact
  assign xe   = XY_W'($signed(XIN));
  assign ye   = XY_W'($signed(YIN));
  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    xf_d    = xf_q;
    ang_d   = ang_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROT;
          i_d     = '0;
          zero_d  = (XIN == '0) && (YIN == '0);
          if (!xe[XY_W-1]) begin
            x_d = xe;
            y_d = ye;
            z_d = '0;
          end else if (!ye[XY_W-1]) begin
            x_d = ye;
            y_d = -xe;
            z_d = PI_2_S;
          end else begin
            x_d = -ye;
            y_d = xe;
            z_d = -PI_2_S;
          end
        end
      end
      S_ROT: begin
        if (i_q == LAST_I) begin
          state_d = S_FIN;
          xf_d    = x_q;
          // The rotation leaves z arbitrary for a zero vector, so force it
          ang_d   = zero_q ? '0 : z_q;
        end else begin
          i_d = i_q + IDX_W'(1);
          if (!y_q[XY_W-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + $signed(atan_i);
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - $signed(atan_i);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      xf_q    <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      xf_q    <= xf_d;
      ang_q   <= ang_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_FIN);
  assign XF    = xf_q;
  assign ANGLE = ang_q;

endmodule

// File: doc/cordic_vec.md
CORDIC_VEC -- requirements
Module: cordic_vec

Interface
REQ-001 The block SHALL have parameter NITER, default 24, setting the number of CORDIC micro-rotations (legal range 16..30).
REQ-002 The block SHALL have parameter ANG_FRAC, default 29, setting the fractional bits of the ANGLE output (3Q29 radians).
REQ-003 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request a conversion of XIN/YIN, sampled on the clock edge.
REQ-006 Port: XIN  input  32  signed X component, two's complement.
REQ-007 Port: YIN  input  32  signed Y component, two's complement.
REQ-008 Port: busy  output  1  high while a conversion is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when XF/ANGLE become valid.
REQ-010 Port: XF  output  34  signed unscaled modulus (gain about 1.6468), consumed directly by the downstream scale-factor stage.
REQ-011 Port: ANGLE  output  32  signed atan2(YIN,XIN) in radians, 3Q29.

Function
REQ-012 The block SHALL be an FSM with states IDLE, ROT and FIN.
- IDLE -> ROT on start.
- ROT -> FIN after NITER iterations.
- FIN -> IDLE after one cycle.
REQ-013 A start in IDLE SHALL sign-extend XIN/YIN to 34 bits, apply the quadrant pre-rotation, load x, y, z, clear the iteration counter i and enter ROT.
REQ-014 Pre-rotation SHALL be:
- XIN>=0: x=X, y=Y, z=0.
- XIN<0 and YIN>=0: x=Y, y=-X, z=+pi/2.
- XIN<0 and YIN<0: x=-Y, y=X, z=-pi/2.
REQ-015 Each ROT cycle SHALL perform one step:
- y>=0: x+=y>>>i, y-=x>>>i, z+=atan(2^-i).
- y<0: x-=y>>>i, y+=x>>>i, z-=atan(2^-i).
- In both cases i increments and all right shifts are arithmetic.
REQ-016 x and y SHALL be 34-bit signed; z SHALL be 32-bit 3Q29; no saturation is required because the ranges are proven non-overflowing.
REQ-017 In FIN the block SHALL register XF=x and ANGLE=z and assert done for exactly that cycle.
REQ-018 Latency SHALL be fixed: a start sampled at edge k gives done high in the cycle after edge k+NITER+1.
REQ-019 busy SHALL be high in ROT and FIN and low in IDLE.
REQ-020 start while busy SHALL be ignored, with no queuing and no corruption of the running conversion.
REQ-021 start on the same edge that returns the FSM from FIN to IDLE SHALL be ignored; start SHALL be accepted only when busy is low.
REQ-022 XF and ANGLE SHALL hold their last values between done pulses and SHALL change only in FIN.
REQ-023 XIN=YIN=0 SHALL produce XF=0 and ANGLE=0, via a zero flag captured at start that forces z=0 in FIN.
REQ-024 XIN or YIN equal to -2^31 SHALL be handled exactly, since the negation is done after extension to 34 bits.

Reset
REQ-025 Reset SHALL force the FSM to IDLE and clear the counter, x, y, z, XF, ANGLE, done and busy to 0, independently of clock.
REQ-026 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after reset release SHALL behave normally.

Structure
REQ-027 A shared package cordic_pkg SHALL hold the FSM state encoding, the width constants (34, 32, ANG_FRAC), the constants PI_2 = 843314857 and the atan table (round(atan(2^-i)*2^29), i=0..29).
REQ-028 The atan table SHALL be a combinational sub-module cordic_atan_rom (input i, output 32-bit angle); the datapath and FSM SHALL stay in cordic_vec.

Verification
REQ-029 XIN=1000, YIN=0, start -> done exactly NITER+2 cycles after start; XF=1647+/-3; ANGLE=0+/-256.
REQ-030 XIN=0, YIN=1000 -> XF=1647+/-3; ANGLE=843314857+/-256.
REQ-031 XIN=-1000, YIN=0 -> ANGLE=1686629713+/-256 (+pi); XIN=-2^31, YIN=-2^31 -> XF=5001302000+/-0.01% and ANGLE=-1264972285+/-256.
REQ-032 XIN=YIN=0 -> XF=0, ANGLE=0; start pulsed at cycles 3 and 10 of a running conversion -> ignored, and exactly one done with correct results.
REQ-033 Reset asserted at iteration 10 -> busy=0, XF=0, ANGLE=0 and no done; a new start after release -> correct results with nominal latency.
REQ-034 Back-to-back: start held high continuously -> conversions every NITER+3 cycles, done one cycle wide, XF/ANGLE stable between pulses.
